// File: rtl/hub75_linebuf.sv
// Double-buffered HUB75 line buffer: upstream fills the back bank while the
// output stage reads single bit-planes of the front bank; a swap exchanges them.
module hub75_linebuf #(
  parameter  int COLBITS   = 6,
  parameter  int BITDEPTH  = 8,
  localparam int PLANEBITS = $clog2(BITDEPTH),
  localparam int PIXW      = 6 * BITDEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [PIXW-1:0]      wr_data,
  input  logic                 wr_last,
  input  logic                 rd_en,
  input  logic [COLBITS-1:0]   rd_col,
  input  logic [PLANEBITS-1:0] rd_plane,
  output logic [2:0]           rgb1,
  output logic [2:0]           rgb2,
  output logic                 rd_valid,
  input  logic                 swap,
  output logic                 back_full,
  output logic                 underrun
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wstate_e;

  localparam logic [COLBITS-1:0] LAST_COL = '1;

  wstate_e                state_q, state_d;
  logic [COLBITS-1:0]     wcol_q, wcol_d;
  logic                   fsel_q, fsel_d;
  logic                   underrun_q, underrun_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [PLANEBITS-1:0]   rd_plane_q, rd_plane_d;
  logic                   have_q, have_d;

  logic                   wr_en;
  logic [COLBITS:0]       wr_addr;
  logic [COLBITS:0]       rd_addr;
  logic [PLANEBITS-1:0]   plane_sat;
  logic [2:0]             rgb1_bits;
  logic [2:0]             rgb2_bits;

  // Both banks share one array; the bank select is the top address bit.
  logic [PIXW-1:0]        mem [0:(2**(COLBITS+1))-1];
  logic [PIXW-1:0]        rd_word;

  always_comb begin
    state_d    = state_q;
    wcol_d     = wcol_q;
    fsel_d     = fsel_q;
    underrun_d = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      FILL: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wr_last || (wcol_q == LAST_COL)) begin
            state_d = FULL;
          end else begin
            wcol_d = wcol_q + COLBITS'(1);
          end
        end
        // A swap that arrives before the line is complete is refused, even
        // when the completing write lands in the same cycle.
        if (swap) begin
          underrun_d = 1'b1;
        end
      end
      FULL: begin
        if (swap) begin
          fsel_d  = ~fsel_q;
          wcol_d  = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    if (32'(rd_plane) >= BITDEPTH) begin
      plane_sat = PLANEBITS'(BITDEPTH - 1);
    end else begin
      plane_sat = rd_plane;
    end
    rd_valid_d = rd_en;
    rd_plane_d = rd_en ? plane_sat : rd_plane_q;
    have_d     = have_q | rd_en;
  end

  assign wr_addr = {~fsel_q, wcol_q};
  assign rd_addr = {fsel_q, rd_col};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      wcol_q     <= '0;
      fsel_q     <= 1'b0;
      underrun_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_plane_q <= '0;
      have_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcol_q     <= wcol_d;
      fsel_q     <= fsel_d;
      underrun_q <= underrun_d;
      rd_valid_q <= rd_valid_d;
      rd_plane_q <= rd_plane_d;
      have_q     <= have_d;
    end
  end

  // Kept free of reset so the array and its read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_word <= mem[rd_addr];
    end
  end

  always_comb begin
    rgb1_bits = 3'b000;
    rgb2_bits = 3'b000;
    for (int i = 0; i < BITDEPTH; i++) begin
      if (rd_plane_q == PLANEBITS'(i)) begin
        rgb1_bits = {rd_word[5*BITDEPTH+i], rd_word[4*BITDEPTH+i], rd_word[3*BITDEPTH+i]};
        rgb2_bits = {rd_word[2*BITDEPTH+i], rd_word[BITDEPTH+i], rd_word[i]};
      end
    end
  end

  // The RAM read register has no reset, so the outputs are masked until a
  // read has completed since reset.
  assign rgb1      = have_q ? rgb1_bits : 3'b000;
  assign rgb2      = have_q ? rgb2_bits : 3'b000;
  assign rd_valid  = rd_valid_q;
  assign wr_ready  = (state_q == FILL);
  assign back_full = (state_q == FULL);
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_hub75_linebuf.sv
// Self-checking bench for hub75_linebuf: directed writes, swaps and reads with
// a read-data scoreboard and inline status checks.
module tb_hub75_linebuf;

   localparam int COLBITS   = 6;
   localparam int BITDEPTH  = 8;
   localparam int PLANEBITS = 3;
   localparam int PIXW      = 48;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 wr_valid = 1'b0;
   logic                 wr_ready;
   logic [PIXW-1:0]      wr_data = '0;
   logic                 wr_last = 1'b0;
   logic                 rd_en = 1'b0;
   logic [COLBITS-1:0]   rd_col = '0;
   logic [PLANEBITS-1:0] rd_plane = '0;
   logic [2:0]           rgb1;
   logic [2:0]           rgb2;
   logic                 rd_valid;
   logic                 swap = 1'b0;
   logic                 back_full;
   logic                 underrun;

   int total = 0;
   int bad = 0;
   logic [5:0] expQ [$];
   logic [5:0] monExp;

   hub75_linebuf #(.COLBITS(COLBITS), .BITDEPTH(BITDEPTH)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
      .rd_en(rd_en), .rd_col(rd_col), .rd_plane(rd_plane),
      .rgb1(rgb1), .rgb2(rgb2), .rd_valid(rd_valid),
      .swap(swap), .back_full(back_full), .underrun(underrun)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Pixel patterns, each {R1,G1,B1,R2,G2,B2}.
   function automatic logic [PIXW-1:0] pixA(input logic [7:0] c);
      return {c, 8'h00, 8'hFF, 8'h00, c, 8'h00};
   endfunction
   function automatic logic [PIXW-1:0] pixB(input logic [7:0] c);
      return {8'h00, 8'hFF, c, c, 8'h00, 8'hFF};
   endfunction
   function automatic logic [PIXW-1:0] pixC(input logic [7:0] c);
      return {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF | c};
   endfunction
   function automatic logic [PIXW-1:0] pixD(input logic [7:0] c);
      return {8'h3C, c, 8'hC3, c, 8'h5A, 8'hA5};
   endfunction
   function automatic logic [PIXW-1:0] pixE(input logic [7:0] c);
      return {8'h00, 8'h00, 8'h00, 8'hFF, c, c};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives every input for exactly one clock, queueing the expected read
   // result when a read is requested.
   task automatic applyStimulus(input logic wv, input logic [PIXW-1:0] d, input logic last,
                                input logic re, input logic [COLBITS-1:0] col,
                                input logic [PLANEBITS-1:0] pl, input logic sw,
                                input logic [5:0] expRgb);
      wr_valid = wv;
      wr_data  = d;
      wr_last  = last;
      rd_en    = re;
      rd_col   = col;
      rd_plane = pl;
      swap     = sw;
      if (re) expQ.push_back(expRgb);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      rd_en    = 1'b0;
      swap     = 1'b0;
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 6'b0);
   endtask

   task automatic readPix(input logic [COLBITS-1:0] col, input logic [PLANEBITS-1:0] pl, input logic [5:0] expRgb);
      applyStimulus(1'b0, '0, 1'b0, 1'b1, col, pl, 1'b0, expRgb);
   endtask

   task automatic doSwap();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 6'b0);
   endtask

   // Read monitor: every rd_valid must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && rd_valid) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_read: got %b_%b expected no read", rgb1, rgb2);
            end else begin
               monExp = expQ.pop_front();
               checkOutput("read_rgb", {26'b0, rgb1, rgb2}, {26'b0, monExp});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #3;
      checkOutput("reset_wr_ready", wr_ready, 1);
      checkOutput("reset_back_full", back_full, 0);
      checkOutput("reset_underrun", underrun, 0);
      checkOutput("reset_rd_valid", rd_valid, 0);
      checkOutput("reset_rgb1", rgb1, 0);
      checkOutput("reset_rgb2", rgb2, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] full line fill and backpressure");
      for (int c = 0; c < 64; c++) begin
         checkOutput("fill_a_wr_ready", wr_ready, 1);
         applyStimulus(1'b1, pixA(8'(c)), c == 63, 1'b0, '0, '0, 1'b0, 6'b0);
      end
      checkOutput("fill_a_back_full", back_full, 1);
      checkOutput("fill_a_wr_ready_low", wr_ready, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b0, 6'b0);
         checkOutput("held_wr_ready", wr_ready, 0);
         checkOutput("held_back_full", back_full, 1);
      end
      doSwap();
      checkOutput("swap_a_wr_ready", wr_ready, 1);
      checkOutput("swap_a_back_full", back_full, 0);
      checkOutput("swap_a_underrun", underrun, 0);
      readPix(6'd5, 3'd0, 6'b101_010);
      readPix(6'd5, 3'd1, 6'b001_000);
      readPix(6'd5, 3'd7, 6'b001_000);
      readPix(6'd63, 3'd5, 6'b101_010);
      readPix(6'd63, 3'd0, 6'b101_010);

      $display("[TB] short line");
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b1, pixB(8'(c)), c == 9, 1'b0, '0, '0, 1'b0, 6'b0);
      end
      checkOutput("short_back_full", back_full, 1);
      checkOutput("short_wr_ready", wr_ready, 0);
      readPix(6'd9, 3'd0, 6'b101_010);
      doSwap();
      readPix(6'd9, 3'd0, 6'b011_101);
      readPix(6'd9, 3'd3, 6'b011_101);
      readPix(6'd9, 3'd1, 6'b010_001);

      $display("[TB] underrun cases");
      doSwap();
      checkOutput("underrun_fill_pulse", underrun, 1);
      checkOutput("underrun_fill_back_full", back_full, 0);
      checkOutput("underrun_fill_wr_ready", wr_ready, 1);
      idle();
      checkOutput("underrun_fill_end", underrun, 0);
      readPix(6'd9, 3'd1, 6'b010_001);
      readPix(6'd0, 3'd0, 6'b010_001);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, pixC(8'(c)), 1'b0, 1'b0, '0, '0, 1'b0, 6'b0);
      end
      applyStimulus(1'b1, pixC(8'd4), 1'b1, 1'b0, '0, '0, 1'b1, 6'b0);
      checkOutput("underrun_coinc_pulse", underrun, 1);
      checkOutput("underrun_coinc_back_full", back_full, 1);
      checkOutput("underrun_coinc_wr_ready", wr_ready, 0);
      idle();
      checkOutput("underrun_coinc_end", underrun, 0);
      checkOutput("underrun_coinc_still_full", back_full, 1);
      readPix(6'd0, 3'd0, 6'b010_001);

      $display("[TB] swap and read collision");
      applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd0, 3'd0, 1'b1, 6'b010_001);
      checkOutput("collision_underrun", underrun, 0);
      checkOutput("collision_back_full", back_full, 0);
      checkOutput("collision_wr_ready", wr_ready, 1);
      readPix(6'd0, 3'd0, 6'b111_111);

      $display("[TB] mid-fill reset");
      for (int c = 0; c < 30; c++) begin
         applyStimulus(1'b1, pixD(8'(c)), 1'b0, 1'b0, '0, '0, 1'b0, 6'b0);
      end
      readPix(6'd0, 3'd0, 6'b111_111);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_rd_valid", rd_valid, 0);
      checkOutput("async_rgb1", rgb1, 0);
      checkOutput("async_rgb2", rgb2, 0);
      checkOutput("async_wr_ready", wr_ready, 1);
      checkOutput("async_back_full", back_full, 0);
      checkOutput("async_underrun", underrun, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 64; c++) begin
         checkOutput("refill_wr_ready", wr_ready, 1);
         applyStimulus(1'b1, pixE(8'(c)), c == 63, 1'b0, '0, '0, 1'b0, 6'b0);
      end
      checkOutput("refill_back_full", back_full, 1);
      doSwap();
      readPix(6'd30, 3'd0, 6'b000_100);
      readPix(6'd30, 3'd1, 6'b000_111);
      readPix(6'd5, 3'd2, 6'b000_111);
      readPix(6'd0, 3'd0, 6'b000_100);

      idle();
      idle();
      idle();
      checkOutput("scoreboard_drained", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_linebuf.md
HUB75_LINEBUF -- requirements
Module: hub75_linebuf

Interface
REQ-001 SHALL have parameter COLBITS, default 6: column address width; a line holds 2**COLBITS columns.
REQ-002 SHALL have parameter BITDEPTH, default 8: bits per colour channel; must be a power of two, 2..8.
REQ-003 SHALL have derived localparam PLANEBITS = log2(BITDEPTH) and localparam PIXW = 6*BITDEPTH.
REQ-004 SHALL have port clk  input  1: sole clock, rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port wr_valid  input  1: upstream pixel-pair valid.
REQ-007 SHALL have port wr_ready  output  1: block can accept a pixel pair.
REQ-008 SHALL have port wr_data  input  PIXW: {R1,G1,B1,R2,G2,B2}, each BITDEPTH wide, MSB first; 1 = upper half-panel, 2 = lower.
REQ-009 SHALL have port wr_last  input  1: the accepted pair is the final column of the line.
REQ-010 SHALL have port rd_en  input  1: read request from the output stage.
REQ-011 SHALL have port rd_col  input  COLBITS: column to read.
REQ-012 SHALL have port rd_plane  input  PLANEBITS: bit-plane to read; 0 = LSB.
REQ-013 SHALL have port rgb1  output  3: {R1,G1,B1} bit for rd_plane, registered.
REQ-014 SHALL have port rgb2  output  3: {R2,G2,B2} bit for rd_plane, registered.
REQ-015 SHALL have port rd_valid  output  1: rgb1/rgb2 hold a read result.
REQ-016 SHALL have port swap  input  1: single-cycle pulse from the driver at a row boundary.
REQ-017 SHALL have port back_full  output  1: the back bank holds a complete line.
REQ-018 SHALL have port underrun  output  1: one-cycle pulse when a swap is refused.

Function
REQ-019 SHALL contain two banks (front/back), each 2**COLBITS x PIXW, with a 1-bit front-bank pointer fsel.
REQ-020 SHALL write only to the back bank and read only from the front bank.
REQ-021 SHALL implement the write FSM with states FILL and FULL; wr_ready = 1 in FILL and 0 in FULL.
REQ-022 SHALL, in FILL when wr_valid && wr_ready, write wr_data to back[wcol] and increment wcol.
REQ-023 SHALL go to FULL when the accepted pair has wr_last = 1 or wcol = 2**COLBITS-1; wcol does not wrap.
REQ-024 SHALL drive back_full = 1 exactly while in FULL.
REQ-025 SHALL, on swap in FULL, toggle fsel, clear wcol to 0 and return to FILL; the first write may be accepted the following cycle.
REQ-026 SHALL, on swap in FILL, leave fsel, wcol and the back bank unchanged and pulse underrun high for exactly one cycle; the front line is redisplayed.
REQ-027 SHALL treat swap in the same cycle as the accepting write that completes the line as an underrun; that write is still accepted and the FSM enters FULL.
REQ-028 SHALL leave unwritten columns (short lines) with stale contents; the output stage is responsible for blanking them.
REQ-029 SHALL have read latency of exactly 1 cycle: rd_en in cycle N sets rd_valid = 1 and rgb1 = {R1[p],G1[p],B1[p]}, rgb2 = {R2[p],G2[p],B2[p]} of front[rd_col] in cycle N+1.
REQ-030 SHALL keep rgb1/rgb2 at their last values and drive rd_valid = 0 when rd_en = 0.
REQ-031 SHALL, when rd_en and swap coincide, return data from the pre-swap front bank; the new fsel applies from the next rd_en.
REQ-032 SHALL treat rd_plane >= BITDEPTH as plane BITDEPTH-1 (saturate).
REQ-033 SHALL make the banks inferable as iCE40 block RAM: one synchronous write port and one synchronous read port, with bank select as a high address bit.

Reset
REQ-034 SHALL, while reset = 1, asynchronously force: state FILL, wcol 0, fsel 0, wr_ready 1, back_full 0, underrun 0, rd_valid 0, rgb1 000, rgb2 000.
REQ-035 SHALL leave bank contents undefined after reset; reads before the first swap return don't-care data.
REQ-036 SHALL abandon a partial line when reset is asserted mid-fill, then restart at wcol 0 after deassertion.
REQ-037 SHALL accept the first wr_valid in the first clk edge after reset deasserts.

Verification
REQ-038 SHALL cover fill-and-swap: write 64 pairs, col c = {R1=c,G1=0,B1=FF,R2=0,G2=c,B2=0}, last on c=63, then swap; read col 5 plane 0 -> rgb1 101, rgb2 010, and plane 1 -> rgb1 001, rgb2 000, each 1 cycle after rd_en.
REQ-039 SHALL cover backpressure: after 64 writes back_full = 1 and wr_ready = 0; hold wr_valid for 10 cycles -> no write, wcol unchanged; after swap, wr_ready = 1 next cycle.
REQ-040 SHALL cover short line: wr_last on the 10th pair -> back_full = 1; swap; read col 9 -> the 10th pair's bits.
REQ-041 SHALL cover underrun: swap in FILL, and swap coincident with the line-completing write -> underrun pulses 1 cycle each time, fsel unchanged, and the old line is still read.
REQ-042 SHALL cover swap/read collision: rd_en col 0 on the swap cycle -> old front data; rd_en on the next cycle -> new front data.
REQ-043 SHALL cover mid-fill reset: assert reset after 30 writes -> all outputs at reset values immediately (asynchronous), wr_ready = 1; 64 new writes + swap -> reads match the new data.
